// File: rtl/memory_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM encoding, load-word
// variant encodings, HI/LO control bit positions and extension helpers.
package memory_stage_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } mem_state_e;

  // Encodings of the 2-bit LW_EXE_MEM field (00 = no word-class load)
  localparam logic [1:0] LW_RIGHT = 2'b01;
  localparam logic [1:0] LW_LEFT  = 2'b10;
  localparam logic [1:0] LW_WORD  = 2'b11;

  // Bit positions inside MFHL_EXE_MEM / MTHL_EXE_MEM
  localparam int HL_HI_BIT = 1;
  localparam int HL_LO_BIT = 0;

  function automatic logic [DATA_W-1:0] sext8(input logic [7:0] b);
    logic signed [7:0] s;
    s = b;
    return DATA_W'(s);
  endfunction

  function automatic logic [DATA_W-1:0] sext16(input logic [15:0] h);
    logic signed [15:0] s;
    s = h;
    return DATA_W'(s);
  endfunction

endpackage

// File: rtl/memory_stage_load_align.sv
// Combinational load aligner: extracts and extends bytes/halves and merges
// unaligned LWL/LWR data with the old register contents (rt).
module load_align
  import memory_stage_pkg::*;
(
  input  logic [1:0]        addr,
  input  logic [DATA_W-1:0] rd,
  input  logic [DATA_W-1:0] rt,
  input  logic              lb,
  input  logic              lbu,
  input  logic              lh,
  input  logic              lhu,
  input  logic [1:0]        lw,
  output logic [DATA_W-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rd[{addr, 3'b000} +: 8];
  assign half_sel = rd[{addr[1], 4'b0000} +: 16];

  // Pick the extension/merge that matches the active load type
  always_comb begin
    data = rd;
    if (lb) begin
      data = sext8(byte_sel);
    end else if (lbu) begin
      data = {24'b0, byte_sel};
    end else if (lh) begin
      data = sext16(half_sel);
    end else if (lhu) begin
      data = {16'b0, half_sel};
    end else begin
      case (lw)
        LW_LEFT: begin
          case (addr)
            2'd0:    data = {rd[7:0],  rt[23:0]};
            2'd1:    data = {rd[15:0], rt[15:0]};
            2'd2:    data = {rd[23:0], rt[7:0]};
            default: data = rd;
          endcase
        end
        LW_RIGHT: begin
          case (addr)
            2'd0:    data = rd;
            2'd1:    data = {rt[31:24], rd[31:8]};
            2'd2:    data = {rt[31:16], rd[31:16]};
            default: data = {rt[31:8],  rd[31:24]};
          endcase
        end
        LW_WORD: data = rd;
        default: data = rd;
      endcase
    end
  end

endmodule

// File: rtl/memory_stage.sv
// MEM pipeline stage: data-SRAM handshake, load alignment, HI/LO ownership,
// writeback selection and the MEM/WB pipeline register.
module memory_stage
  import memory_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_EXE_MEM,
  input  logic              MemEn_EXE_MEM,
  input  logic              MemToReg_EXE_MEM,
  input  logic [3:0]        MemWrite_EXE_MEM,
  input  logic [3:0]        RegWrite_EXE_MEM,
  input  logic [4:0]        RegWaddr_EXE_MEM,
  input  logic [1:0]        MULT_EXE_MEM,
  input  logic [1:0]        MFHL_EXE_MEM,
  input  logic [1:0]        MTHL_EXE_MEM,
  input  logic              LB_EXE_MEM,
  input  logic              LBU_EXE_MEM,
  input  logic              LH_EXE_MEM,
  input  logic              LHU_EXE_MEM,
  input  logic [1:0]        LW_EXE_MEM,
  input  logic              mfc0_EXE_MEM,
  input  logic [DATA_W-1:0] ALUResult_EXE_MEM,
  input  logic [DATA_W-1:0] MemWdata_EXE_MEM,
  input  logic [DATA_W-1:0] PC_EXE_MEM,
  input  logic [DATA_W-1:0] RegRdata1_EXE_MEM,
  input  logic [DATA_W-1:0] RegRdata2_EXE_MEM,
  input  logic [DATA_W-1:0] cp0Rdata_EXE_MEM,
  input  logic [63:0]       Product_EXE_MEM,
  output logic              data_req,
  output logic              data_wr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic [DATA_W-1:0] data_rdata,
  input  logic              data_data_ok,
  output logic              stall_MEM,
  output logic [DATA_W-1:0] Bypass_MEM,
  output logic              valid_MEM_WB,
  output logic [3:0]        RegWrite_MEM_WB,
  output logic [4:0]        RegWaddr_MEM_WB,
  output logic [DATA_W-1:0] RegWdata_MEM_WB,
  output logic [DATA_W-1:0] PC_MEM_WB
);

  mem_state_e        state, state_nxt;
  logic              mem_op;
  logic              retire;
  logic [DATA_W-1:0] hi_p1, lo_p1;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] wb_data;

  assign mem_op = valid_EXE_MEM & MemEn_EXE_MEM;
  assign retire = valid_EXE_MEM & ~stall_MEM;

  // Request fields come straight from EXE/MEM, which upstream holds while stalled
  assign data_wr    = |MemWrite_EXE_MEM;
  assign data_wstrb = MemWrite_EXE_MEM;
  assign data_addr  = {ALUResult_EXE_MEM[DATA_W-1:2], 2'b00};
  assign data_wdata = MemWdata_EXE_MEM;

  // Handshake state register
  always_ff @(posedge clk) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Handshake next-state, request and stall generation
  always_comb begin
    state_nxt = state;
    data_req  = 1'b0;
    stall_MEM = 1'b0;
    case (state)
      ST_IDLE: begin
        data_req  = mem_op;
        stall_MEM = mem_op;
        if (mem_op) state_nxt = data_addr_ok ? ST_WAIT : ST_REQ;
      end
      ST_REQ: begin
        data_req  = 1'b1;
        stall_MEM = mem_op;
        if (data_addr_ok) state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        stall_MEM = mem_op & ~data_data_ok;
        if (data_data_ok) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  load_align u_load_align (
    .addr (ALUResult_EXE_MEM[1:0]),
    .rd   (data_rdata),
    .rt   (RegRdata2_EXE_MEM),
    .lb   (LB_EXE_MEM),
    .lbu  (LBU_EXE_MEM),
    .lh   (LH_EXE_MEM),
    .lhu  (LHU_EXE_MEM),
    .lw   (LW_EXE_MEM),
    .data (load_data)
  );

  // Writeback value select, highest priority first
  always_comb begin
    wb_data = ALUResult_EXE_MEM;
    if (MemToReg_EXE_MEM)             wb_data = load_data;
    else if (mfc0_EXE_MEM)            wb_data = cp0Rdata_EXE_MEM;
    else if (MFHL_EXE_MEM[HL_HI_BIT]) wb_data = hi_p1;
    else if (MFHL_EXE_MEM[HL_LO_BIT]) wb_data = lo_p1;
  end

  assign Bypass_MEM = wb_data;

  // HI/LO update on retire; an MT* in the same instruction overrides the product
  always_ff @(posedge clk) begin
    if (!rst) begin
      hi_p1 <= '0;
      lo_p1 <= '0;
    end else if (retire) begin
      if (MULT_EXE_MEM != 2'b00) begin
        hi_p1 <= Product_EXE_MEM[63:32];
        lo_p1 <= Product_EXE_MEM[31:0];
      end
      if (MTHL_EXE_MEM[HL_HI_BIT]) hi_p1 <= RegRdata1_EXE_MEM;
      if (MTHL_EXE_MEM[HL_LO_BIT]) lo_p1 <= RegRdata1_EXE_MEM;
    end
  end

  // MEM/WB register; a stalled cycle pushes a bubble into WB
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_MEM_WB    <= 1'b0;
      RegWrite_MEM_WB <= '0;
      RegWaddr_MEM_WB <= '0;
      RegWdata_MEM_WB <= '0;
      PC_MEM_WB       <= '0;
    end else if (retire) begin
      valid_MEM_WB    <= 1'b1;
      RegWrite_MEM_WB <= RegWrite_EXE_MEM;
      RegWaddr_MEM_WB <= RegWaddr_EXE_MEM;
      RegWdata_MEM_WB <= wb_data;
      PC_MEM_WB       <= PC_EXE_MEM;
    end else begin
      valid_MEM_WB    <= 1'b0;
      RegWrite_MEM_WB <= '0;
    end
  end

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a reference model.
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_EXE_MEM, MemEn_EXE_MEM, MemToReg_EXE_MEM;
  logic [3:0]  MemWrite_EXE_MEM, RegWrite_EXE_MEM;
  logic [4:0]  RegWaddr_EXE_MEM;
  logic [1:0]  MULT_EXE_MEM, MFHL_EXE_MEM, MTHL_EXE_MEM, LW_EXE_MEM;
  logic        LB_EXE_MEM, LBU_EXE_MEM, LH_EXE_MEM, LHU_EXE_MEM, mfc0_EXE_MEM;
  logic [31:0] ALUResult_EXE_MEM, MemWdata_EXE_MEM, PC_EXE_MEM;
  logic [31:0] RegRdata1_EXE_MEM, RegRdata2_EXE_MEM, cp0Rdata_EXE_MEM;
  logic [63:0] Product_EXE_MEM;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        stall_MEM;
  logic [31:0] Bypass_MEM;
  logic        valid_MEM_WB;
  logic [3:0]  RegWrite_MEM_WB;
  logic [4:0]  RegWaddr_MEM_WB;
  logic [31:0] RegWdata_MEM_WB, PC_MEM_WB;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk(clk), .rst(rst),
    .valid_EXE_MEM(valid_EXE_MEM), .MemEn_EXE_MEM(MemEn_EXE_MEM),
    .MemToReg_EXE_MEM(MemToReg_EXE_MEM), .MemWrite_EXE_MEM(MemWrite_EXE_MEM),
    .RegWrite_EXE_MEM(RegWrite_EXE_MEM), .RegWaddr_EXE_MEM(RegWaddr_EXE_MEM),
    .MULT_EXE_MEM(MULT_EXE_MEM), .MFHL_EXE_MEM(MFHL_EXE_MEM), .MTHL_EXE_MEM(MTHL_EXE_MEM),
    .LB_EXE_MEM(LB_EXE_MEM), .LBU_EXE_MEM(LBU_EXE_MEM), .LH_EXE_MEM(LH_EXE_MEM),
    .LHU_EXE_MEM(LHU_EXE_MEM), .LW_EXE_MEM(LW_EXE_MEM), .mfc0_EXE_MEM(mfc0_EXE_MEM),
    .ALUResult_EXE_MEM(ALUResult_EXE_MEM), .MemWdata_EXE_MEM(MemWdata_EXE_MEM),
    .PC_EXE_MEM(PC_EXE_MEM), .RegRdata1_EXE_MEM(RegRdata1_EXE_MEM),
    .RegRdata2_EXE_MEM(RegRdata2_EXE_MEM), .cp0Rdata_EXE_MEM(cp0Rdata_EXE_MEM),
    .Product_EXE_MEM(Product_EXE_MEM),
    .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
    .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_rdata(data_rdata), .data_data_ok(data_data_ok),
    .stall_MEM(stall_MEM), .Bypass_MEM(Bypass_MEM),
    .valid_MEM_WB(valid_MEM_WB), .RegWrite_MEM_WB(RegWrite_MEM_WB),
    .RegWaddr_MEM_WB(RegWaddr_MEM_WB), .RegWdata_MEM_WB(RegWdata_MEM_WB),
    .PC_MEM_WB(PC_MEM_WB)
  );

  typedef struct {
    logic        mem_en, mem_to_reg, lb, lbu, lh, lhu, mfc0;
    logic [3:0]  mem_write, reg_write;
    logic [4:0]  waddr;
    logic [1:0]  mult, mfhl, mthl, lw;
    logic [31:0] alu, wdata, pc, rs, rt, cp0, rdata;
    logic [63:0] prod;
  } instr_t;

  typedef struct {
    instr_t      in;
    logic [31:0] exp;
  } vec_t;

  int          tot = 0;
  int          bad = 0;
  logic [63:0] hilo;   // reference {HI,LO}

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic instr_t nop_instr();
    instr_t i;
    i = '{default: '0};
    return i;
  endfunction

  // t: 0 LB 1 LBU 2 LH 3 LHU 4 LW 5 LWL 6 LWR
  function automatic instr_t mk_load(input int t, input logic [1:0] a,
                                     input logic [31:0] rd, input logic [31:0] rt);
    instr_t i;
    i = nop_instr();
    i.mem_en = 1'b1; i.mem_to_reg = 1'b1; i.reg_write = 4'hF;
    i.alu = 32'h2000_0010 | {30'b0, a};
    i.rdata = rd; i.rt = rt;
    i.waddr = 5'(t + 3); i.pc = 32'hBFC0_0000 + 32'(t * 4);
    case (t)
      0: i.lb = 1'b1;
      1: i.lbu = 1'b1;
      2: i.lh = 1'b1;
      3: i.lhu = 1'b1;
      4: i.lw = 2'b11;
      5: i.lw = 2'b10;
      default: i.lw = 2'b01;
    endcase
    return i;
  endfunction

  // Reference load result, computed with shifts and masks
  function automatic logic [31:0] model_load(input instr_t i);
    int a, sh;
    logic [31:0] b, h, mask;
    a = int'(i.alu[1:0]);
    sh = 8 * a;
    b = (i.rdata >> sh) & 32'hFF;
    h = (i.rdata >> (16 * int'(i.alu[1]))) & 32'hFFFF;
    if (i.lb)  return b[7]  ? b - 32'd256   : b;
    if (i.lbu) return b;
    if (i.lh)  return h[15] ? h - 32'd65536 : h;
    if (i.lhu) return h;
    if (i.lw == 2'b10) begin
      mask = (32'd1 << (8 * (3 - a))) - 32'd1;
      return (i.rdata << (8 * (3 - a))) | (i.rt & mask);
    end
    if (i.lw == 2'b01) begin
      mask = ~(32'hFFFF_FFFF >> sh);
      return (i.rdata >> sh) | (i.rt & mask);
    end
    return i.rdata;
  endfunction

  function automatic logic [31:0] model_wb(input instr_t i);
    if (i.mem_to_reg) return model_load(i);
    if (i.mfc0)       return i.cp0;
    if (i.mfhl[1])    return hilo[63:32];
    if (i.mfhl[0])    return hilo[31:0];
    return i.alu;
  endfunction

  task automatic model_commit(input instr_t i);
    if (i.mult != 2'b00) hilo = i.prod;
    if (i.mthl[1]) hilo[63:32] = i.rs;
    if (i.mthl[0]) hilo[31:0]  = i.rs;
  endtask

  task automatic apply(input instr_t i, input logic v);
    valid_EXE_MEM = v; MemEn_EXE_MEM = i.mem_en; MemToReg_EXE_MEM = i.mem_to_reg;
    MemWrite_EXE_MEM = i.mem_write; RegWrite_EXE_MEM = i.reg_write;
    RegWaddr_EXE_MEM = i.waddr; MULT_EXE_MEM = i.mult; MFHL_EXE_MEM = i.mfhl;
    MTHL_EXE_MEM = i.mthl; LB_EXE_MEM = i.lb; LBU_EXE_MEM = i.lbu; LH_EXE_MEM = i.lh;
    LHU_EXE_MEM = i.lhu; LW_EXE_MEM = i.lw; mfc0_EXE_MEM = i.mfc0;
    ALUResult_EXE_MEM = i.alu; MemWdata_EXE_MEM = i.wdata; PC_EXE_MEM = i.pc;
    RegRdata1_EXE_MEM = i.rs; RegRdata2_EXE_MEM = i.rt; cp0Rdata_EXE_MEM = i.cp0;
    Product_EXE_MEM = i.prod; data_rdata = i.rdata;
  endtask

  // Present one instruction (called at posedge+1), act as the SRAM with
  // addr_ok after 'a' cycles and data_ok 1+'d' cycles after acceptance,
  // then check the MEM/WB contents one edge after retirement.
  task automatic run_instr(input instr_t i, input int a, input int d,
                           input logic [31:0] exp, input string nm);
    bit m, accepted, retired;
    int acc_cyc, cyc;
    m = i.mem_en; accepted = 0; retired = 0; acc_cyc = 0; cyc = 0;
    apply(i, 1'b1);
    while (!retired && cyc < 40) begin
      data_addr_ok = m && !accepted && (cyc >= a);
      data_data_ok = m && accepted && (cyc == acc_cyc + 1 + d);
      @(negedge clk);
      chk({nm, ".stall"}, 64'(stall_MEM), 64'(m && (cyc != a + 1 + d)));
      if (m) begin
        chk({nm, ".req"},   64'(data_req),   64'(cyc <= a));
        chk({nm, ".wr"},    64'(data_wr),    64'(|i.mem_write));
        chk({nm, ".wstrb"}, 64'(data_wstrb), 64'(i.mem_write));
        chk({nm, ".wdata"}, 64'(data_wdata), 64'(i.wdata));
        chk({nm, ".addr"},  64'(data_addr),  64'({i.alu[31:2], 2'b00}));
      end
      if (cyc > 0) begin
        chk({nm, ".bubble_valid"}, 64'(valid_MEM_WB),    64'(0));
        chk({nm, ".bubble_we"},    64'(RegWrite_MEM_WB), 64'(0));
      end
      if (!stall_MEM) begin
        retired = 1;
        chk({nm, ".bypass"}, 64'(Bypass_MEM), 64'(exp));
      end
      if (data_req && data_addr_ok) begin
        accepted = 1; acc_cyc = cyc;
      end
      @(posedge clk); #1;
      cyc++;
    end
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    chk({nm, ".retired"}, 64'(retired), 64'(1));
    chk({nm, ".valid"},   64'(valid_MEM_WB),    64'(1));
    chk({nm, ".wdata_wb"}, 64'(RegWdata_MEM_WB), 64'(exp));
    chk({nm, ".we"},      64'(RegWrite_MEM_WB), 64'(i.reg_write));
    chk({nm, ".waddr"},   64'(RegWaddr_MEM_WB), 64'(i.waddr));
    chk({nm, ".pc"},      64'(PC_MEM_WB),       64'(i.pc));
    if (retired) model_commit(i);
  endtask

  task automatic idle(input string nm);
    apply(nop_instr(), 1'b0);
    @(posedge clk); #1;
    chk({nm, ".valid"}, 64'(valid_MEM_WB),    64'(0));
    chk({nm, ".we"},    64'(RegWrite_MEM_WB), 64'(0));
  endtask

  function automatic instr_t rand_instr();
    instr_t i;
    i = nop_instr();
    i.waddr = 5'($urandom); i.pc = $urandom; i.alu = $urandom; i.rs = $urandom;
    i.rt = $urandom; i.cp0 = $urandom; i.rdata = $urandom; i.wdata = $urandom;
    i.prod = {$urandom, $urandom}; i.reg_write = 4'hF;
    case ($urandom_range(0, 8))
      0: ;
      1: begin i.mult = 2'($urandom_range(1, 3)); i.reg_write = 4'h0; end
      2: begin i.mthl = 2'b10; i.reg_write = 4'h0; end
      3: begin i.mthl = 2'b01; i.reg_write = 4'h0; end
      4: i.mfhl = 2'b10;
      5: i.mfhl = 2'b01;
      6: i.mfc0 = 1'b1;
      7: i = mk_load($urandom_range(0, 6), 2'($urandom), $urandom, $urandom);
      default: begin
        i.mem_en = 1'b1; i.mem_write = 4'($urandom_range(1, 15)); i.reg_write = 4'h0;
      end
    endcase
    return i;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    instr_t i;
    vec_t   vecs [8];
    logic [31:0] e;

    // Reset state
    rst = 1'b0; hilo = '0;
    apply(nop_instr(), 1'b0);
    data_addr_ok = 1'b0; data_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", 64'(valid_MEM_WB),    64'(0));
    chk("rst.we",    64'(RegWrite_MEM_WB), 64'(0));
    chk("rst.waddr", 64'(RegWaddr_MEM_WB), 64'(0));
    chk("rst.wdata", 64'(RegWdata_MEM_WB), 64'(0));
    chk("rst.pc",    64'(PC_MEM_WB),       64'(0));
    @(negedge clk);
    chk("rst.req",   64'(data_req),  64'(0));
    chk("rst.stall", 64'(stall_MEM), 64'(0));
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    // LW with addr_ok and data_ok each one cycle late
    i = mk_load(4, 2'b00, 32'hDEAD_BEEF, 32'h0);
    i.alu = 32'h1000_0004;
    run_instr(i, 1, 1, 32'hDEAD_BEEF, "lw_late");
    idle("lw_once");

    // Directed load-alignment table
    vecs[0] = '{mk_load(0, 2'd3, 32'h80AA_BBCC, 32'h0),         32'hFFFF_FF80};
    vecs[1] = '{mk_load(1, 2'd3, 32'h80AA_BBCC, 32'h0),         32'h0000_0080};
    vecs[2] = '{mk_load(2, 2'd2, 32'h8001_0000, 32'h0),         32'hFFFF_8001};
    vecs[3] = '{mk_load(5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344), 32'hCCDD_3344};
    vecs[4] = '{mk_load(6, 2'd2, 32'hAABB_CCDD, 32'h1122_3344), 32'h1122_AABB};
    vecs[5] = '{mk_load(3, 2'd0, 32'h1234_F00D, 32'h0),         32'h0000_F00D};
    vecs[6] = '{mk_load(6, 2'd3, 32'hAABB_CCDD, 32'h1122_3344), 32'h1122_33AA};
    vecs[7] = '{mk_load(0, 2'd1, 32'h80AA_BBCC, 32'h0),         32'hFFFF_FFBB};
    for (int k = 0; k < 8; k++)
      run_instr(vecs[k].in, 0, 0, vecs[k].exp, $sformatf("vec%0d", k));

    // Store waits for data_ok, then ALU op retires back-to-back
    i = nop_instr();
    i.mem_en = 1'b1; i.mem_write = 4'b0100; i.wdata = 32'h00AB_0000;
    i.alu = 32'h3000_0006; i.pc = 32'h100; i.waddr = 5'd9;
    run_instr(i, 1, 2, 32'h3000_0006, "store");
    i = nop_instr();
    i.alu = 32'h1234_5678; i.reg_write = 4'hF; i.waddr = 5'd4; i.pc = 32'h104;
    run_instr(i, 0, 0, 32'h1234_5678, "alu_after_store");

    // MULT then MFHI, MTLO then MFLO, MFC0
    i = nop_instr(); i.mult = 2'b01; i.prod = 64'h1_0000_0002; i.alu = 32'h77;
    run_instr(i, 0, 0, 32'h77, "mult");
    i = nop_instr(); i.mfhl = 2'b10; i.reg_write = 4'hF; i.waddr = 5'd2;
    run_instr(i, 0, 0, 32'h1, "mfhi");
    i = nop_instr(); i.mthl = 2'b01; i.rs = 32'h55;
    run_instr(i, 0, 0, 32'h0, "mtlo");
    i = nop_instr(); i.mfhl = 2'b01; i.reg_write = 4'hF; i.waddr = 5'd3;
    run_instr(i, 0, 0, 32'h55, "mflo");
    i = nop_instr(); i.mfc0 = 1'b1; i.cp0 = 32'hC0C0_0001; i.reg_write = 4'hF;
    run_instr(i, 0, 0, 32'hC0C0_0001, "mfc0");

    // Randomized instruction stream against the reference model
    for (int n = 0; n < 80; n++) begin
      i = rand_instr();
      e = model_wb(i);
      run_instr(i, $urandom_range(0, 2), $urandom_range(0, 2), e, $sformatf("rnd%0d", n));
    end

    // Reset while a load is waiting for data_ok
    i = nop_instr(); i.mult = 2'b11; i.prod = 64'hABCD_0001_0000_1234;
    run_instr(i, 0, 0, 32'h0, "mult2");
    i = mk_load(4, 2'd0, 32'hCAFE_F00D, 32'h0);
    apply(i, 1'b1);
    data_addr_ok = 1'b1;
    @(negedge clk);
    chk("rstw.req", 64'(data_req), 64'(1));
    @(posedge clk); #1;
    apply(nop_instr(), 1'b0);
    data_addr_ok = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; hilo = '0; data_data_ok = 1'b1;
    chk("rstw.valid", 64'(valid_MEM_WB),    64'(0));
    chk("rstw.we",    64'(RegWrite_MEM_WB), 64'(0));
    chk("rstw.pc",    64'(PC_MEM_WB),       64'(0));
    @(negedge clk);
    chk("rstw.stall", 64'(stall_MEM), 64'(0));
    chk("rstw.req",   64'(data_req),  64'(0));
    @(posedge clk); #1;
    data_data_ok = 1'b0;
    chk("rstw.late_ok_valid", 64'(valid_MEM_WB), 64'(0));
    i = nop_instr(); i.mfhl = 2'b10; i.reg_write = 4'hF;
    run_instr(i, 0, 0, 32'h0, "rstw.mfhi");
    i = nop_instr(); i.mfhl = 2'b01; i.reg_write = 4'hF;
    run_instr(i, 0, 0, 32'h0, "rstw.mflo");
    i = mk_load(4, 2'd0, 32'h0BAD_CAFE, 32'h0);
    run_instr(i, 0, 0, 32'h0BAD_CAFE, "rstw.lw");
    idle("end");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of execute: consumes the EXE/MEM pipeline register contents.
- Drives the data-SRAM request/response handshake and aligns/merges load data (LB/LBU/LH/LHU/LW/LWL/LWR).
- Owns the HI/LO registers (MULT result, MTHI/MTLO, MFHI/MFLO), selects the writeback value and registers everything into MEM/WB.
- Stalls upstream stages while a memory access is outstanding.

Parameters:
- none (widths fixed at 32-bit MIPS datapath)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- valid_EXE_MEM  in  1  instruction present in MEM
- MemEn_EXE_MEM  in  1  instruction accesses data memory
- MemToReg_EXE_MEM  in  1  writeback value is load data
- MemWrite_EXE_MEM  in  4  byte write strobes (0 = load)
- RegWrite_EXE_MEM  in  4  register byte write enables
- RegWaddr_EXE_MEM  in  5  destination register
- MULT_EXE_MEM  in  2  nonzero = multiply, write product to HI/LO
- MFHL_EXE_MEM  in  2  [1] MFHI, [0] MFLO
- MTHL_EXE_MEM  in  2  [1] MTHI, [0] MTLO
- LB/LBU/LH/LHU_EXE_MEM  in  1 each  load type
- LW_EXE_MEM  in  2  11 LW, 10 LWL, 01 LWR, 00 none
- mfc0_EXE_MEM  in  1  writeback value is cp0Rdata
- ALUResult_EXE_MEM  in  32  effective address / ALU result
- MemWdata_EXE_MEM  in  32  pre-aligned store data
- PC_EXE_MEM, RegRdata1_EXE_MEM, RegRdata2_EXE_MEM, cp0Rdata_EXE_MEM  in  32 each
- Product_EXE_MEM  in  64  multiplier result {hi,lo}
- data_req  out  1  memory request
- data_wr  out  1  request is a write
- data_wstrb  out  4  byte strobes
- data_addr  out  32  word-aligned address
- data_wdata  out  32  write data
- data_addr_ok  in  1  request accepted
- data_rdata  in  32  read data
- data_data_ok  in  1  response (read data valid / write done)
- stall_MEM  out  1  hold EXE and earlier stages
- Bypass_MEM  out  32  forwarding value (writeback value)
- valid_MEM_WB  out  1
- RegWrite_MEM_WB  out  4
- RegWaddr_MEM_WB  out  5
- RegWdata_MEM_WB  out  32
- PC_MEM_WB  out  32

Behaviour:
- Reset (rst==0 at posedge): FSM=IDLE; HI=LO=0; all *_MEM_WB=0. Combinational outputs then read data_req=0, stall_MEM=0. A data_data_ok arriving after reset is ignored.
- mem_op = valid_EXE_MEM & MemEn_EXE_MEM.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if mem_op then addr_ok ? WAIT : REQ.
  - REQ: if addr_ok then WAIT.
  - WAIT: if data_ok then IDLE.
- data_req = (IDLE & mem_op) | REQ. data_wr = |MemWrite. data_wstrb = MemWrite. data_addr = {ALUResult[31:2],2'b00}. data_wdata = MemWdata. All held stable while data_req=1 and addr_ok=0.
- Minimum access latency is 2 cycles: req+addr_ok in cycle 0, data_ok in cycle 1. A store also waits for data_ok.
- stall_MEM = mem_op & ~(WAIT & data_ok).
- retire = valid_EXE_MEM & ~stall_MEM. Instructions without MemEn retire in the cycle they enter (0 extra latency).
- Load align (addr = ALUResult[1:0], rd = data_rdata, rt = RegRdata2):
  - LB/LBU: byte[addr], sign-/zero-extended.
  - LH/LHU: half[addr[1]], sign-/zero-extended.
  - LW: rd.
  - LWL: addr0 {rd[7:0],rt[23:0]}; 1 {rd[15:0],rt[15:0]}; 2 {rd[23:0],rt[7:0]}; 3 rd.
  - LWR: addr0 rd; 1 {rt[31:24],rd[31:8]}; 2 {rt[31:16],rd[31:16]}; 3 {rt[31:8],rd[31:24]}.
- Writeback mux, priority order: MemToReg→aligned load; mfc0→cp0Rdata; MFHI→HI; MFLO→LO; else ALUResult. Bypass_MEM is the same value, unregistered.
- MEM/WB regs:
  - On retire: load all fields, valid_MEM_WB=1.
  - If not retiring: valid_MEM_WB=0 and RegWrite_MEM_WB=0, so a bubble is inserted behind a stall.
- HI/LO update only on retire:
  - MULT≠0: {HI,LO}<=Product.
  - MTHI: HI<=RegRdata1.
  - MTLO: LO<=RegRdata1.
  - MFHI/MFLO in the cycle immediately after MULT/MT* retired read the updated values.
- Upstream must hold EXE/MEM contents while stall_MEM=1; inputs are sampled again each cycle.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=0, REQ=1, WAIT=2).
  - LW_EXE_MEM encodings (LW/LWL/LWR).
  - MFHL/MTHL bit positions.
- One combinational sub-module, load_align: inputs addr[1:0], rd, rt, load-type flags; output 32-bit data.

Test Plan:
- Load word, addr_ok and data_ok each 1 cycle late: ALUResult=0x1000_0004, rdata=0xDEADBEEF → data_req high 2 cycles, stall_MEM high 3 cycles, RegWdata_MEM_WB=0xDEADBEEF, valid for 1 cycle.
- LB/LBU at addr[1:0]=3, rdata=0x80AA_BBCC → LB result 0xFFFFFF80, LBU result 0x00000080. LH at addr 2, rdata=0x8001_0000 → 0xFFFF8001.
- LWL/LWR, rt=0x11223344, rdata=0xAABBCCDD → LWL addr1 gives 0xCCDD3344; LWR addr2 gives 0x1122AABB.
- Store with wstrb=4'b0100: data_wr=1, wstrb and wdata held until data_ok, then RegWrite_MEM_WB=0. Back-to-back ALU instruction retires the next cycle with stall_MEM=0.
- MULT with Product=0x1_0000_0002, then MFHI next cycle → RegWdata=0x1. MTLO with RegRdata1=0x55, then MFLO → 0x55.
- rst=0 asserted while in WAIT → next cycle FSM IDLE, HI=LO=0, valid_MEM_WB=0. A late data_ok is ignored (no writeback).
